// File: rtl/key_input_conditioner_if.sv
// rtl/key_input_conditioner_if.sv - raw key inputs and conditioned key outputs grouped as one port bundle
interface key_input_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n_in;
  logic [NUM_KEYS-1:0] keys_level;
  logic [NUM_KEYS-1:0] keys_press;
  logic [NUM_KEYS-1:0] keys_release;

  modport master (
    output key_n_in,
    input  keys_level,
    input  keys_press,
    input  keys_release
  );

  modport slave (
    input  key_n_in,
    output keys_level,
    output keys_press,
    output keys_release
  );
endinterface

// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - sync, debounce and press/release strobes for active-low pushbuttons
// Optional auto-repeat of keys_press while held: define KEY_AUTOREPEAT_EN.
module key_input_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  key_input_conditioner_if.slave    kif
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  // Sync flops hold raw (active-low) polarity, so reset to 1 means "released".
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= kif.key_n_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;
`ifdef KEY_AUTOREPEAT_EN
    logic             rep_q, rep_d;
`endif

    assign s       = ~sync2_q[i];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_q     <= 1'b0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef KEY_AUTOREPEAT_EN
        rep_q     <= rep_d;
`endif
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_d     = rep_q;
`endif
      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_PEND;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_PEND;
            cnt_d   = CNT_W'(1);
          end
`ifdef KEY_AUTOREPEAT_EN
          // First repeat waits the long delay, later ones the shorter period.
          else if (cnt_q == (rep_q ? PER_LAST : DLY_LAST)) begin
            press_d = 1'b1;
            cnt_d   = '0;
            rep_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end
        RELEASE_PEND: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_d   = 1'b0;
`endif
          end else if (cnt_q == DEB_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    assign kif.keys_level[i]   = level_q;
    assign kif.keys_press[i]   = press_q;
    assign kif.keys_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb/tb_key_input_conditioner.sv - directed and random checks of key_input_conditioner against a run-length model
module tb_key_input_conditioner;
  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int CW   = 6;
  localparam int RDLY = 20;
  localparam int RPER = 10;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_input_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_input_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW),
    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .kif(kif)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;
  int edge_cnt = 0;

  // Model: a key's level flips once DEB consecutive synchronised samples disagree with it.
  logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_release;
  int m_run [NK];
  int m_hold[NK];
  int m_due [NK];

  always @(posedge clk) begin
    logic [NK-1:0] s;
    edge_cnt++;
    if (!reset_n) begin
      m_d1 = '1; m_d2 = '1;
      m_level = '0; m_press = '0; m_release = '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k] = 0; m_hold[k] = 0; m_due[k] = RDLY;
      end
    end else begin
      s = ~m_d2;
      m_d2 = m_d1;
      m_d1 = kif.key_n_in;
      m_press = '0;
      m_release = '0;
      for (int k = 0; k < NK; k++) begin
        if (s[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_level[k] = ~m_level[k];
            if (m_level[k]) m_press[k] = 1'b1;
            else            m_release[k] = 1'b1;
            m_run[k] = 0; m_hold[k] = 0; m_due[k] = RDLY;
          end
        end else begin
          if (m_level[k] && AR) begin
            if (m_run[k] > 0) begin
              m_hold[k] = 0; m_due[k] = RDLY;
            end else begin
              m_hold[k]++;
              if (m_hold[k] == m_due[k]) begin
                m_press[k] = 1'b1; m_hold[k] = 0; m_due[k] = RPER;
              end
            end
          end
          m_run[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, edge_cnt, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_level",   kif.keys_level,   m_level);
      chk("model_press",   kif.keys_press,   m_press);
      chk("model_release", kif.keys_release, m_release);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold_left[NK];
    logic strobe_seen;
    logic exp_rep;

    // 1: reset
    kif.key_n_in = 4'hF;
    reset_n = 1'b0;
    step(1);
    checking = 1'b1;
    step(2);
    chk("rst_level", kif.keys_level, 4'b0000);
    chk("rst_press", kif.keys_press, 4'b0000);
    chk("rst_release", kif.keys_release, 4'b0000);
    reset_n = 1'b1;
    step(1);
    chk("post_rst_press", kif.keys_press, 4'b0000);
    step(4);

    // 2: single press and release with exact latency
    kif.key_n_in[0] = 1'b0;
    step(9);
    chk("t2_press_early", kif.keys_press, 4'b0000);
    step(1);
    chk("t2_press_e10", kif.keys_press, 4'b0001);
    chk("t2_level_e10", kif.keys_level, 4'b0001);
    step(1);
    chk("t2_press_e11", kif.keys_press, 4'b0000);
    step(19);
    kif.key_n_in[0] = 1'b1;
    step(9);
    chk("t2_level_e39", kif.keys_level, 4'b0001);
    step(1);
    chk("t2_release_e40", kif.keys_release, 4'b0001);
    chk("t2_level_e40", kif.keys_level, 4'b0000);
    step(3);

    // 3: bounce shorter than the debounce window
    strobe_seen = 1'b0;
    kif.key_n_in[2] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5)  kif.key_n_in[2] = 1'b1;
      if (i == 7)  kif.key_n_in[2] = 1'b0;
      if (i == 12) kif.key_n_in[2] = 1'b1;
      step(1);
      strobe_seen = strobe_seen | kif.keys_press[2] | kif.keys_release[2] | kif.keys_level[2];
    end
    chk("t3_bounce_quiet", {3'b000, strobe_seen}, 4'b0000);

    // 4: two keys together
    kif.key_n_in = 4'b0101;
    step(10);
    chk("t4_press", kif.keys_press, 4'b1010);
    chk("t4_level", kif.keys_level, 4'b1010);
    step(1);
    chk("t4_press_gone", kif.keys_press, 4'b0000);
    kif.key_n_in = 4'hF;
    step(14);

    // 5: reset mid-count
    kif.key_n_in[0] = 1'b0;
    step(6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("t5_level_after_rst", kif.keys_level, 4'b0000);
    step(9);
    chk("t5_press_early", kif.keys_press, 4'b0000);
    step(1);
    chk("t5_press", kif.keys_press, 4'b0001);
    kif.key_n_in[0] = 1'b1;
    step(14);

    // 6: long hold, repeat strobes only when auto-repeat is built in
    kif.key_n_in[0] = 1'b0;
    step(10);
    chk("t6_press_e10", kif.keys_press, 4'b0001);
    for (int e = 11; e <= 70; e++) begin
      step(1);
      exp_rep = AR && (e >= 30) && ((e - 30) % 10 == 0);
      chk("t6_repeat", {3'b000, kif.keys_press[0]}, {3'b000, exp_rep});
    end
    kif.key_n_in[0] = 1'b1;
    step(14);

    // random bouncing, occasional resets
    for (int k = 0; k < NK; k++) hold_left[k] = $urandom_range(1, 20);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold_left[k] == 0) begin
          kif.key_n_in[k] = ~kif.key_n_in[k];
          hold_left[k] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 40);
        end else begin
          hold_left[k]--;
        end
      end
      reset_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    reset_n = 1'b1;
    kif.key_n_in = 4'hF;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
